alex_relay_sequencer: RTL

Sequences every Alex filter/T-R relay change so the transmitter is never keyed through a switching relay. Sits between the band decoders (one-hot LPF/HPF selections) plus the PTT request and the Alex serial relay interface. On any change it mutes TX, shifts a 16-bit relay word out serially, strobes the latch and waits for relay settling before re-permitting TX.

---
 rtl/alex_pkg.sv | 34 +++
 rtl/alex_spi_shifter.sv | 86 ++++++++
 rtl/alex_relay_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alex_pkg.sv
// alex_pkg: shared definitions for the Alex relay sequencer.
//   - Relay word layout: T/R relay on bit 15, LPF code on 14:8, HPF code on 5:0.
//   - LPF one-hot constants for the codes the sequencer refers to by name.
//   - FSM state enum and a one-hot helper for validating the LPF request.
package alex_pkg;

    localparam int WORD_W  = 16;
    localparam int TR_BIT  = 15;
    localparam int LPF_MSB = 14;
    localparam int LPF_LSB = 8;
    localparam int HPF_MSB = 5;
    localparam int HPF_LSB = 0;
    localparam int LPF_W   = LPF_MSB - LPF_LSB + 1;
    localparam int HPF_W   = HPF_MSB - HPF_LSB + 1;

    localparam logic [LPF_W-1:0] LPF_6M   = 7'b0010000;
    localparam logic [LPF_W-1:0] LPF_160M = 7'b0001000;
    // An invalid LPF request falls back to the 6m filter.
    localparam logic [LPF_W-1:0] LPF_SAFE = LPF_6M;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUTE,
        ST_SHIFT,
        ST_LOAD,
        ST_SETTLE
    } state_e;

    // True when exactly one bit is set: clearing the lowest set bit leaves zero.
    function automatic logic lpf_is_onehot(input logic [LPF_W-1:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction

endpackage

// File: rtl/alex_spi_shifter.sv
// alex_spi_shifter: 16-bit load/shift serializer for the Alex relay board.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   start_i    load word_i and begin shifting on the next cycle
//   word_i     word to send, MSB first
//   done_o     high during the final cycle of the last bit (combinational)
//   sck_o      serial clock: low SPI_DIV cycles, then high SPI_DIV cycles per bit
//   data_o     serial data; holds the last bit (bit 0) once shifting ends
module alex_spi_shifter
    import alex_pkg::*;
#(
    parameter int SPI_DIV = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              done_o,
    output logic              sck_o,
    output logic              data_o
);

    localparam int DIV_W = $clog2(SPI_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SPI_DIV - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic              sck_q, sck_d;
    logic              act_q, act_d;

    always_comb begin
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        act_d   = act_q;
        done_o  = 1'b0;
        if (start_i) begin
            shreg_d = word_i;
            div_d   = DIV_RELOAD;
            bit_d   = 4'd15;
            sck_d   = 1'b0;
            act_d   = 1'b1;
        end else if (act_q) begin
            if (div_q == '0) begin
                div_d = DIV_RELOAD;
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        // Register is not shifted so data keeps showing bit 0.
                        act_d  = 1'b0;
                        done_o = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                        bit_d   = bit_q - 4'd1;
                    end
                end
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            act_q   <= act_d;
        end
    end

    assign sck_o  = sck_q;
    assign data_o = shreg_q[WORD_W-1];

endmodule

// File: rtl/alex_relay_sequencer.sv
// alex_relay_sequencer: mutes TX around every Alex relay change.
//   clock      system clock
//   reset      asynchronous active-high reset
//   lpf_sel    one-hot LPF code (non one-hot is replaced by 6m and blocks TX)
//   hpf_sel    one-hot HPF code
//   ptt        TX request (synchronous)
//   tx_enable  registered TX permission
//   spi_sck    Alex serial clock (idles low)
//   spi_data   Alex serial data, MSB first
//   spi_load   Alex latch strobe
//   busy       high whenever a relay sequence is in progress
module alex_relay_sequencer
    import alex_pkg::*;
#(
    parameter int SPI_DIV       = 24,
    parameter int MUTE_CYCLES   = 48000,
    parameter int SETTLE_CYCLES = 480000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LPF_W-1:0] lpf_sel,
    input  logic [HPF_W-1:0] hpf_sel,
    input  logic             ptt,
    output logic             tx_enable,
    output logic             spi_sck,
    output logic             spi_data,
    output logic             spi_load,
    output logic             busy
);

    localparam int MAX_A = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (MAX_A > SPI_DIV) ? MAX_A : SPI_DIV;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0] applied_q, applied_d;
    logic              dirty_q, dirty_d;
    logic              tx_q, busy_q, load_q;

    logic              req_valid;
    logic [LPF_W-1:0]  lpf_eff;
    logic [WORD_W-1:0] req_word;
    logic              mismatch;
    logic              shift_start;
    logic              shift_done;

    assign req_valid = lpf_is_onehot(lpf_sel);
    assign lpf_eff   = req_valid ? lpf_sel : LPF_SAFE;
    assign req_word  = {ptt, lpf_eff, 2'b00, hpf_sel};
    assign mismatch  = (req_word != applied_q) || dirty_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        applied_d   = applied_q;
        dirty_d     = dirty_q;
        shift_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mismatch) begin
                    state_d  = ST_MUTE;
                    cnt_d    = CNT_W'(MUTE_CYCLES - 1);
                    shadow_d = req_word;
                end
            end
            ST_MUTE: begin
                if (cnt_q == '0) begin
                    // Shifter loads now so bit 15 is on the wire in the first SHIFT cycle.
                    state_d     = ST_SHIFT;
                    shift_start = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(SPI_DIV - 1);
                end
            end
            ST_LOAD: begin
                if (cnt_q == '0) begin
                    applied_d = shadow_q;
                    dirty_d   = 1'b0;
                    state_d   = ST_SETTLE;
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            applied_q <= '0;
            dirty_q   <= 1'b1;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            applied_q <= applied_d;
            dirty_q   <= dirty_d;
            // Any mismatch drops TX on the next cycle, ahead of any relay motion.
            tx_q      <= (state_q == ST_IDLE) && ptt && applied_q[TR_BIT]
                         && !mismatch && req_valid;
            busy_q    <= (state_d != ST_IDLE);
            load_q    <= (state_d == ST_LOAD);
        end
    end

    alex_spi_shifter #(
        .SPI_DIV (SPI_DIV)
    ) u_shifter (
        .clk_i   (clock),
        .rst_i   (reset),
        .start_i (shift_start),
        .word_i  (shadow_q),
        .done_o  (shift_done),
        .sck_o   (spi_sck),
        .data_o  (spi_data)
    );

    assign tx_enable = tx_q;
    assign busy      = busy_q;
    assign spi_load  = load_q;

endmodule
